// File: rtl/sdram_wr_burst_buf_if.sv
// Write-stream and burst-issue signals of the SDRAM write burst buffer.
// The master drives words in and plays the controller; the slave is the buffer.
interface sdram_wr_burst_buf_if #(
    parameter int BURST_LEN = 8
);
    localparam int CW = $clog2(BURST_LEN) + 1;

    logic [15:0]   wr_data;
    logic [31:0]   wr_addr;
    logic          wr_valid;
    logic          wr_ready;
    logic          bst_req;
    logic [31:0]   bst_addr;
    logic [CW-1:0] bst_len;
    logic          bst_ack;
    logic          bst_rd;
    logic [15:0]   bst_data;
    logic          bst_done;

    modport master (
        output wr_data, wr_addr, wr_valid, bst_ack, bst_rd,
        input  wr_ready, bst_req, bst_addr, bst_len, bst_data, bst_done
    );

    modport slave (
        input  wr_data, wr_addr, wr_valid, bst_ack, bst_rd,
        output wr_ready, bst_req, bst_addr, bst_len, bst_data, bst_done
    );
endinterface

// File: rtl/sdram_wr_burst_buf.sv
// Collects address-contiguous write words into two ping-pong banks and hands
// each closed bank to the SDRAM controller as a single request/pull burst.
module sdram_wr_burst_buf #(
    parameter int BURST_LEN = 8,
    parameter int TIMEOUT   = 256
) (
    input  logic                sdram_clk_i,
    input  logic                rst_i,
    sdram_wr_burst_buf_if.slave bus
);
    localparam int LW = $clog2(BURST_LEN);
    localparam int CW = LW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {B_FREE, B_FILL, B_READY, B_XFER} bank_st_e;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_DONE} fsm_st_e;

    bank_st_e      bank_st_q [2];
    bank_st_e      bank_st_d [2];
    logic [31:0]   base_q [2];
    logic [31:0]   base_d [2];
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic [15:0]   mem_q [2][BURST_LEN];
    logic          fill_sel_q, fill_sel_d;
    logic          srv_sel_q, srv_sel_d;
    logic [LW-1:0] rd_idx_q, rd_idx_d;
    logic [TW-1:0] idle_q, idle_d;
    fsm_st_e       state_q, state_d;

    bank_st_e      fill_st;
    logic [CW-1:0] fill_cnt;
    logic [31:0]   next_addr;
    logic          fill_open;
    logic          disc;
    logic          wr_ready;
    logic          accept;
    logic          last_word;
    logic          tmo;
    logic          close;
    logic          xfer_last;
    logic          other_free;

    always_comb begin
        fill_st    = bank_st_q[fill_sel_q];
        fill_cnt   = cnt_q[fill_sel_q];
        next_addr  = base_q[fill_sel_q] + 32'(fill_cnt);
        fill_open  = (fill_st == B_FREE) || (fill_st == B_FILL);
        disc       = bus.wr_valid && (fill_st == B_FILL) && (bus.wr_addr != next_addr);
        wr_ready   = !rst_i && fill_open && !disc;
        accept     = bus.wr_valid && wr_ready;
        // Closing on an all-ones low address keeps bursts inside one aligned block.
        last_word  = accept && ((fill_cnt == CW'(BURST_LEN - 1)) || (&bus.wr_addr[LW-1:0]));
        tmo        = (fill_st == B_FILL) && !accept && (idle_q >= TW'(TIMEOUT - 1));
        close      = last_word || disc || tmo;
        xfer_last  = (state_q == S_XFER) && bus.bst_rd &&
                     ({1'b0, rd_idx_q} == (cnt_q[srv_sel_q] - CW'(1)));
        other_free = (bank_st_q[!fill_sel_q] == B_FREE) ||
                     (xfer_last && (srv_sel_q != fill_sel_q));
    end

    always_comb begin
        bank_st_d  = bank_st_q;
        base_d     = base_q;
        cnt_d      = cnt_q;
        fill_sel_d = fill_sel_q;
        srv_sel_d  = srv_sel_q;
        idle_d     = idle_q;
        if (accept) begin
            if (fill_cnt == '0) begin
                base_d[fill_sel_q] = bus.wr_addr;
            end
            cnt_d[fill_sel_q]     = fill_cnt + CW'(1);
            bank_st_d[fill_sel_q] = B_FILL;
        end
        if (close) begin
            bank_st_d[fill_sel_q] = B_READY;
        end
        if ((state_q == S_REQ) && bus.bst_ack) begin
            bank_st_d[srv_sel_q] = B_XFER;
        end
        if (xfer_last) begin
            bank_st_d[srv_sel_q] = B_FREE;
            cnt_d[srv_sel_q]     = '0;
            srv_sel_d            = !srv_sel_q;
        end
        // Banks close strictly alternately, so serving alternately preserves order.
        if ((close || !fill_open) && other_free) begin
            fill_sel_d = !fill_sel_q;
        end
        if (accept || close) begin
            idle_d = '0;
        end else if ((fill_st == B_FILL) && (idle_q != TW'(TIMEOUT))) begin
            idle_d = idle_q + TW'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        rd_idx_d = rd_idx_q;
        case (state_q)
            S_IDLE: begin
                if (bank_st_q[srv_sel_q] == B_READY) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.bst_ack) begin
                    state_d  = S_XFER;
                    rd_idx_d = '0;
                end
            end
            S_XFER: begin
                if (xfer_last) begin
                    state_d  = S_DONE;
                    rd_idx_d = '0;
                end else if (bus.bst_rd) begin
                    rd_idx_d = rd_idx_q + LW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sdram_clk_i) begin
        if (rst_i) begin
            bank_st_q  <= '{B_FREE, B_FREE};
            base_q     <= '{default: '0};
            cnt_q      <= '{default: '0};
            fill_sel_q <= 1'b0;
            srv_sel_q  <= 1'b0;
            rd_idx_q   <= '0;
            idle_q     <= '0;
            state_q    <= S_IDLE;
        end else begin
            bank_st_q  <= bank_st_d;
            base_q     <= base_d;
            cnt_q      <= cnt_d;
            fill_sel_q <= fill_sel_d;
            srv_sel_q  <= srv_sel_d;
            rd_idx_q   <= rd_idx_d;
            idle_q     <= idle_d;
            state_q    <= state_d;
        end
    end

    always_ff @(posedge sdram_clk_i) begin
        if (accept) begin
            mem_q[fill_sel_q][fill_cnt[LW-1:0]] <= bus.wr_data;
        end
    end

    assign bus.wr_ready = wr_ready;
    assign bus.bst_req  = (state_q == S_REQ);
    assign bus.bst_addr = (state_q == S_REQ) ? base_q[srv_sel_q] : '0;
    assign bus.bst_len  = (state_q == S_REQ) ? cnt_q[srv_sel_q] : '0;
    assign bus.bst_data = (state_q == S_XFER) ? mem_q[srv_sel_q][rd_idx_q] : '0;
    assign bus.bst_done = (state_q == S_DONE);
endmodule

// File: tb/tb_sdram_wr_burst_buf.sv
// Directed bench for sdram_wr_burst_buf: stimulus pushes expected bursts and
// words into queues, a negedge monitor pops and compares what the DUT issues.
module tb_sdram_wr_burst_buf;
    localparam int BL = 8;
    localparam int TO = 256;

    typedef struct {
        logic [31:0] addr;
        int          len;
    } burst_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sdram_wr_burst_buf_if #(.BURST_LEN(BL)) bus ();

    sdram_wr_burst_buf #(.BURST_LEN(BL), .TIMEOUT(TO)) dut (
        .sdram_clk_i (clk),
        .rst_i       (rst),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int errors     = 0;
    int checks     = 0;
    int cyc        = 0;
    int done_cnt   = 0;
    int mon_st     = 0;
    int words_left = 0;
    int acc_cyc    = 0;
    burst_t      exp_burst[$];
    logic [15:0] exp_data[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] dat(input logic [31:0] a);
        return a[15:0] ^ 16'h5A3C;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic expect_burst(input logic [31:0] a, input int len);
        burst_t b;
        b.addr = a;
        b.len  = len;
        exp_burst.push_back(b);
        for (int i = 0; i < len; i++) exp_data.push_back(dat(a + 32'(i)));
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_word(input logic [31:0] a, input int budget);
        int n;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = dat(a);
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.wr_ready) begin
                acc_cyc = cyc;
                break;
            end
            n++;
            if (n > budget) begin
                chk("wr_accept_timeout", 32'(bus.wr_ready), 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.wr_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string nm);
        int n;
        n = 0;
        while ((exp_burst.size() != 0 || exp_data.size() != 0 || mon_st != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk({nm, "_drained"}, 32'(exp_burst.size() + exp_data.size() + mon_st), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk({nm, "_wr_ready"}, 32'(bus.wr_ready), 0);
        chk({nm, "_bst_req"},  32'(bus.bst_req), 0);
        chk({nm, "_bst_addr"}, bus.bst_addr, 0);
        chk({nm, "_bst_len"},  32'(bus.bst_len), 0);
        chk({nm, "_bst_data"}, 32'(bus.bst_data), 0);
        chk({nm, "_bst_done"}, 32'(bus.bst_done), 0);
    endtask

    // Monitor: checks burst headers, pulled words and done pulses against the queues.
    initial begin : monitor
        burst_t b;
        logic [15:0] d;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_st = 0;
                exp_burst.delete();
                exp_data.delete();
            end else begin
                if (mon_st != 2 && bus.bst_done) chk("spurious_done", 32'(bus.bst_done), 0);
                case (mon_st)
                    1: begin
                        if (bus.bst_rd) begin
                            if (exp_data.size() != 0) begin
                                d = exp_data.pop_front();
                                chk("bst_data", 32'(bus.bst_data), 32'(d));
                            end
                            words_left--;
                            if (words_left == 0) mon_st = 2;
                        end
                    end
                    2: begin
                        chk("bst_done", 32'(bus.bst_done), 1);
                        done_cnt++;
                        mon_st = 0;
                    end
                    default: ;
                endcase
                if (mon_st == 0 && bus.bst_req && bus.bst_ack) begin
                    if (exp_burst.size() == 0) begin
                        chk("unexpected_burst", 32'(bus.bst_req), 0);
                    end else begin
                        b = exp_burst.pop_front();
                        chk("bst_addr", bus.bst_addr, b.addr);
                        chk("bst_len", 32'(bus.bst_len), 32'(b.len));
                        words_left = b.len;
                        mon_st = 1;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int d0;
        int found;
        int cnt;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.bst_ack  = 1'b0;
        bus.bst_rd   = 1'b0;

        // Reset values, then wr_ready in the first cycle out of reset.
        @(posedge clk);
        @(negedge clk);
        chk_outputs_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_wr_ready", 32'(bus.wr_ready), 1);
        @(posedge clk);
        #1;
        bus.bst_ack = 1'b1;
        bus.bst_rd  = 1'b1;

        // Contiguous stream 0x100..0x10F.
        expect_burst(32'h100, 8);
        expect_burst(32'h108, 8);
        d0 = done_cnt;
        for (int i = 0; i < 16; i++) send_word(32'h100 + 32'(i), 50);
        wait_drain(200, "contig");
        chk("contig_done_pulses", 32'(done_cnt - d0), 2);

        // Unaligned start closes at the aligned boundary, tail closes on timeout.
        expect_burst(32'h105, 3);
        expect_burst(32'h108, 3);
        for (int i = 0; i < 6; i++) send_word(32'h105 + 32'(i), 50);
        wait_drain(600, "unaligned");

        // Discontinuity: 0x300 refused once, then lands in the other bank.
        expect_burst(32'h200, 2);
        expect_burst(32'h300, 1);
        send_word(32'h200, 50);
        send_word(32'h201, 50);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 32'h300;
        bus.wr_data  = dat(32'h300);
        @(negedge clk);
        chk("disc_ready_low", 32'(bus.wr_ready), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("disc_ready_back", 32'(bus.wr_ready), 1);
        @(posedge clk);
        #1;
        bus.wr_valid = 1'b0;
        wait_drain(600, "disc");

        // Timeout on a single word.
        expect_burst(32'h40, 1);
        send_word(32'h40, 50);
        found = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (bus.bst_req) begin
                found = 1;
                break;
            end
        end
        chk("tmo_req_seen", 32'(found), 1);
        chk("tmo_req_latency", 32'(cyc - acc_cyc), 258);
        @(posedge clk);
        #1;
        wait_drain(100, "timeout");

        // Backpressure: both banks fill while the controller withholds bst_ack.
        bus.bst_ack = 1'b0;
        expect_burst(32'h400, 8);
        expect_burst(32'h408, 8);
        expect_burst(32'h410, 8);
        for (int i = 0; i < 16; i++) send_word(32'h400 + 32'(i), 50);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 32'h410;
        bus.wr_data  = dat(32'h410);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.wr_ready) cnt++;
        end
        chk("bp_ready_low", 32'(cnt), 0);
        chk("bp_req_held", 32'(bus.bst_req), 1);
        @(posedge clk);
        #1;
        bus.bst_ack = 1'b1;
        for (int i = 16; i < 24; i++) send_word(32'h400 + 32'(i), 100);
        wait_drain(300, "backpressure");

        // Reset after three pops of a burst.
        bus.bst_rd = 1'b0;
        expect_burst(32'h500, 8);
        for (int i = 0; i < 8; i++) send_word(32'h500 + 32'(i), 50);
        found = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.bst_req && bus.bst_ack) begin
                found = 1;
                break;
            end
        end
        chk("rst_test_req_seen", 32'(found), 1);
        @(posedge clk);
        #1;
        bus.bst_rd = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        bus.bst_rd = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_outputs_zero("mid_xfer_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_wr_ready", 32'(bus.wr_ready), 1);
        @(posedge clk);
        #1;
        bus.bst_rd = 1'b1;
        cnt = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.bst_req) cnt++;
        end
        chk("no_stale_burst", 32'(cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sdram_wr_burst_buf.md
# sdram_wr_burst_buf

Burst-assembly stage directly downstream of the USB-to-SDRAM write path. It consumes the per-word `wr_data`/`wr_addr`/`wr_valid`/`wr_ready` stream and collects address-contiguous words into ping-pong banks. It then issues each closed bank to the SDRAM controller as one burst: request/acknowledge, followed by word-by-word pull. The block runs entirely in the `sdram_clk` domain.

## Interface
- `BURST_LEN`, 8: words per bank and maximum burst length. Power of 2, ≥2.
- `TIMEOUT`, 256: idle cycles after which a partially filled bank is closed. Must be ≥1.
- `sdram_clk` in 1: single clock for all logic. 133 MHz.
- `rst` in 1: reset. Synchronous, active-high.
- `wr_data` in 16: incoming word.
- `wr_addr` in 32: word address of `wr_data`.
- `wr_valid` in 1: input word valid.
- `wr_ready` out 1: word accepted when `wr_valid & wr_ready` at a rising edge.
- `bst_req` out 1: burst request, held until acknowledged.
- `bst_addr` out 32: start word address of the burst. Stable while `bst_req`.
- `bst_len` out $clog2(BURST_LEN)+1: word count of the burst, 1..BURST_LEN. Stable while `bst_req`.
- `bst_ack` in 1: controller accepts the request. Sampled only while `bst_req` is high.
- `bst_rd` in 1: controller pops one word per cycle while high. Ignored outside XFER.
- `bst_data` out 16: head word of the bank being transferred. Combinational, 0 outside XFER.
- `bst_done` out 1: one-cycle pulse after the last word of a burst is popped.

## Operation
- Storage: two banks of BURST_LEN×16. Each bank has a base address, a count, and a state: FREE, FILL, READY or XFER.
- Fill side:
  - Exactly one bank is the fill bank; the other bank is anything else.
  - A word is written at index `count`; `count` then increments.
  - The first word into an empty bank sets its base address to `wr_addr`.
- Fill bank closes (FILL→READY) at the edge where any of these holds:
  - (a) an accepted word makes `count == BURST_LEN`;
  - (b) an accepted word has `wr_addr[log2(BURST_LEN)-1:0]` all ones. Bursts never cross a BURST_LEN-aligned boundary.
  - (c) discontinuity: `wr_valid` is high, `count > 0`, and `wr_addr != base + count`. The word is NOT accepted (`wr_ready` low that cycle). It is re-presented later and becomes the first word of the next fill bank.
  - (d) the idle counter reaches TIMEOUT while `count > 0`.
- After closing, the fill role moves to the other bank once that bank is FREE.
- `wr_ready` = the fill bank exists and is FREE or FILL, and condition (c) is not true. This is combinational from `wr_valid`/`wr_addr`.
- Idle counter:
  - Increments each cycle the fill bank has `count > 0` and no word is accepted.
  - Clears on accept or close.
  - Saturates at TIMEOUT.
- Issue FSM, states IDLE, REQ, XFER, DONE:
  - IDLE→REQ when the oldest READY bank exists. Banks are served strictly in close order.
  - REQ: `bst_req=1`, with `bst_addr`/`bst_len` taken from that bank. On `bst_ack`, go to XFER.
  - XFER: `bst_data = bank[rd_idx]`. Each `bst_rd` increments `rd_idx`. On the pop where `rd_idx == bst_len-1`, the bank becomes FREE and the FSM goes to DONE.
  - DONE: `bst_done=1` for one cycle, then IDLE.
- Width rules: `base + count` is computed in 32 bits and wraps at 2^32. `bst_len` equals the bank count.
- Reset values: `wr_ready=0` and `bst_req=0`, `bst_addr=0`, `bst_len=0`, `bst_data=0`, `bst_done=0`. After reset, both banks are FREE, bank0 is the fill bank, and the FSM is in IDLE.

## Timing
- `wr_ready` goes high in the first cycle after `rst` deasserts.
- Close latency: a bank closing at edge N is READY in cycle N+1. If the FSM is IDLE, `bst_req` rises at cycle N+2.
- `bst_ack` in the same cycle as `bst_req` leads to XFER in the next cycle. `bst_req` drops in that cycle.
- Word pull: `bst_data` is valid in the same cycle as `bst_rd` and advances at the edge.
- `bst_done` pulses in the cycle after the last pop. The next `bst_req` rises no earlier than the cycle after `bst_done`.
- Simultaneous close of the fill bank and free of the other bank at the same edge is legal. The fill role swaps at that edge.
- Both banks non-FREE means `wr_ready=0` (backpressure). No word is ever dropped.
- `rst` asserted mid-burst: buffered data is discarded, all outputs return to reset values at the next edge, and the FSM returns to IDLE.

## Test plan
- Contiguous stream: 16 words at addr 0x100..0x10F, with `bst_ack`/`bst_rd` always high. Required: two bursts (0x100 len 8, then 0x108 len 8), data in order, two `bst_done` pulses.
- Unaligned start: words at 0x105..0x10A. Required: burst 0x105 len 3, then burst 0x108 len 3.
- Discontinuity: 0x200, 0x201, then 0x300 presented. Required: `wr_ready=0` for one cycle on 0x300; burst 0x200 len 2; then 0x300 is accepted into the other bank.
- Timeout: a single word at 0x40, then idle, with TIMEOUT=256. Required: `bst_req` with `bst_addr=0x40` and `bst_len=1`, rising 258 cycles after the accept.
- Backpressure: `bst_ack` held low while 24 contiguous words are offered. Required: 16 words accepted, then `wr_ready` stays low. After `bst_ack` and the pops, the remaining 8 are accepted with no loss or reorder.
- Reset mid-XFER after 3 pops. Required: all outputs are 0 the next cycle, `wr_ready=1` one cycle after `rst` falls, and no stale burst is issued.
